// File: rtl/modulator_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : modulator_mc                                                 |
// | Description : Multi-channel sine PWM modulator. Each channel walks a       |
// |               shared 2^DEPTH_P-entry sine table and emits one PWM period   |
// |               of 2^WIDTH_P prescaled ticks per sample. Two run-time        |
// |               divisors per channel, switched only at sample boundaries.    |
// | Option      : define MODULATOR_PHASE_OFFSET_EN to add the phase_in port    |
// |               (per-channel start index); otherwise every channel starts    |
// |               at index 0.                                                  |
// | Revision    : 1.0 - initial multi-channel release                          |
// +----------------------------------------------------------------------------+
module modulator_mc #(
    parameter int CHANNELS_P = 2,
    parameter int DEPTH_P    = 8,
    parameter int WIDTH_P    = 12,
    parameter int DIV_W_P    = 32
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [CHANNELS_P-1:0]         en_in,
    input  logic [CHANNELS_P-1:0]         sel_in,
    input  logic [CHANNELS_P*DIV_W_P-1:0] div_high_in,
    input  logic [CHANNELS_P*DIV_W_P-1:0] div_low_in,
`ifdef MODULATOR_PHASE_OFFSET_EN
    input  logic [CHANNELS_P*DEPTH_P-1:0] phase_in,
`endif
    output logic [CHANNELS_P-1:0]         pwm_out,
    output logic [CHANNELS_P-1:0]         sample_stb_out,
    output logic [CHANNELS_P-1:0]         period_stb_out
);

    localparam int  c_rom_depth = 2 ** DEPTH_P;
    localparam real c_pi        = 3.14159265358979323846;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Sine table entry, evaluated at elaboration only. The Taylor series is
    // taken on an angle folded into [-pi, pi] so it converges quickly; the
    // tiny bias keeps entries that land exactly on .5 from rounding down
    // because of floating-point noise around sin(pi) and similar points.
    function automatic logic [WIDTH_P-1:0] f_sine_entry(input int k);
        real ang;
        real term;
        real s;
        real amp;
        real v;
        ang = 2.0 * c_pi * real'(k) / real'(c_rom_depth);
        if (ang > c_pi) begin
            ang = ang - 2.0 * c_pi;
        end
        term = ang;
        s    = ang;
        for (int n = 1; n < 20; n++) begin
            term = -term * ang * ang / real'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        amp = real'((2 ** WIDTH_P) - 1);
        v   = amp * (1.0 + s) / 2.0 + 0.5 + 1.0e-9;
        return WIDTH_P'($rtoi(v));
    endfunction

    logic [WIDTH_P-1:0] w_rom [c_rom_depth];

    for (genvar k = 0; k < c_rom_depth; k++) begin : g_rom
        localparam logic [WIDTH_P-1:0] c_entry = f_sine_entry(k);
        assign w_rom[k] = c_entry;
    end

    for (genvar ch = 0; ch < CHANNELS_P; ch++) begin : g_chan
        state_t               state_q;
        logic [DIV_W_P-1:0]   div_act_q;
        logic [DIV_W_P-1:0]   pre_cnt_q;
        logic [WIDTH_P-1:0]   pwm_cnt_q;
        logic [DEPTH_P-1:0]   idx_q;
        logic [WIDTH_P-1:0]   sample_q;
        logic                 pwm_q;
        logic                 sstb_pend_q;
        logic                 pstb_pend_q;
        logic                 sstb_q;
        logic                 pstb_q;

        logic [DIV_W_P-1:0]   div_sel_d;
        logic [DEPTH_P-1:0]   phase_d;
        logic [DEPTH_P-1:0]   idx_d;
        logic                 tick_d;
        logic                 bnd_d;

        assign div_sel_d = sel_in[ch] ? div_high_in[ch*DIV_W_P +: DIV_W_P]
                                      : div_low_in[ch*DIV_W_P +: DIV_W_P];
`ifdef MODULATOR_PHASE_OFFSET_EN
        assign phase_d   = phase_in[ch*DEPTH_P +: DEPTH_P];
`else
        assign phase_d   = '0;
`endif
        assign idx_d     = idx_q + DEPTH_P'(1);
        // A divisor of 0 or 1 ticks every cycle.
        assign tick_d    = (div_act_q <= DIV_W_P'(1)) ||
                           (pre_cnt_q >= div_act_q - DIV_W_P'(1));
        assign bnd_d     = tick_d && (pwm_cnt_q == {WIDTH_P{1'b1}});

        // Channel FSM with prescaler, PWM counter, sample stepping and
        // registered outputs. Strobes are held one extra cycle in *_pend_q so
        // they line up with the first pwm_out value of the new sample.
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                state_q     <= ST_IDLE;
                div_act_q   <= '0;
                pre_cnt_q   <= '0;
                pwm_cnt_q   <= '0;
                idx_q       <= '0;
                sample_q    <= '0;
                pwm_q       <= 1'b0;
                sstb_pend_q <= 1'b0;
                pstb_pend_q <= 1'b0;
                sstb_q      <= 1'b0;
                pstb_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        pwm_q       <= 1'b0;
                        sstb_pend_q <= 1'b0;
                        pstb_pend_q <= 1'b0;
                        sstb_q      <= 1'b0;
                        pstb_q      <= 1'b0;
                        if (en_in[ch]) begin
                            div_act_q <= div_sel_d;
                            idx_q     <= phase_d;
                            sample_q  <= w_rom[phase_d];
                            pre_cnt_q <= '0;
                            pwm_cnt_q <= '0;
                            state_q   <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (!en_in[ch]) begin
                            // Disable wins over a coinciding boundary.
                            state_q     <= ST_IDLE;
                            div_act_q   <= '0;
                            pre_cnt_q   <= '0;
                            pwm_cnt_q   <= '0;
                            idx_q       <= '0;
                            sample_q    <= '0;
                            pwm_q       <= 1'b0;
                            sstb_pend_q <= 1'b0;
                            pstb_pend_q <= 1'b0;
                            sstb_q      <= 1'b0;
                            pstb_q      <= 1'b0;
                        end else begin
                            pwm_q       <= (pwm_cnt_q < sample_q);
                            sstb_q      <= sstb_pend_q;
                            pstb_q      <= pstb_pend_q;
                            sstb_pend_q <= bnd_d;
                            pstb_pend_q <= bnd_d && (idx_d == '0);
                            if (tick_d) begin
                                pre_cnt_q <= '0;
                                pwm_cnt_q <= pwm_cnt_q + WIDTH_P'(1);
                            end else begin
                                pre_cnt_q <= pre_cnt_q + DIV_W_P'(1);
                            end
                            // Divisor/select changes are only picked up here.
                            if (bnd_d) begin
                                idx_q     <= idx_d;
                                sample_q  <= w_rom[idx_d];
                                div_act_q <= div_sel_d;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end

        assign pwm_out[ch]        = pwm_q;
        assign sample_stb_out[ch] = sstb_q;
        assign period_stb_out[ch] = pstb_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_modulator_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_modulator_mc                                              |
// | Description : Self-checking bench for modulator_mc (2 channels, 8-entry,   |
// |               4-bit sine). Table vectors, directed corner sequences and    |
// |               random stimulus against an event-level reference model.      |
// | Revision    : 1.0 - initial                                                |
// +----------------------------------------------------------------------------+
module tb_modulator_mc;

    localparam int CH  = 2;
    localparam int DEP = 3;
    localparam int WID = 4;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH-1:0]     en;
    logic [CH-1:0]     sel;
    logic [CH*DW-1:0]  dhi;
    logic [CH*DW-1:0]  dlo;
`ifdef MODULATOR_PHASE_OFFSET_EN
    logic [CH*DEP-1:0] phase;
`endif
    logic [CH-1:0]     pwm;
    logic [CH-1:0]     sstb;
    logic [CH-1:0]     pstb;

    modulator_mc #(
        .CHANNELS_P (CH),
        .DEPTH_P    (DEP),
        .WIDTH_P    (WID),
        .DIV_W_P    (DW)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .en_in          (en),
        .sel_in         (sel),
        .div_high_in    (dhi),
        .div_low_in     (dlo),
`ifdef MODULATOR_PHASE_OFFSET_EN
        .phase_in       (phase),
`endif
        .pwm_out        (pwm),
        .sample_stb_out (sstb),
        .period_stb_out (pstb)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    longint e     = 0;
    int     rom_tab [8] = '{8, 13, 15, 13, 8, 2, 0, 2};

    // Reference model: each channel is a sequence of samples; a sample of
    // divisor D lasts 16*D cycles and is high for its first rom*D cycles.
    bit     m_run   [CH];
    int     m_k     [CH];
    int     m_d     [CH];
    longint m_start [CH];
    longint m_bnd   [CH];
    longint m_spend [CH];
    bit     m_pwrap [CH];
    bit     m_pwm   [CH];
    bit     m_s     [CH];
    bit     m_p     [CH];

    typedef struct {
        logic [31:0] div;
        int          win;
        int          exp_high;
    } vec_t;
    vec_t vecs [24];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
        end
    endtask

    function automatic int ph(input int c);
`ifdef MODULATOR_PHASE_OFFSET_EN
        return int'(phase[c*DEP +: DEP]);
`else
        return 0 * c;
`endif
    endfunction

    function automatic int cur_div(input int c);
        logic [31:0] d;
        d = sel[c] ? dhi[c*DW +: DW] : dlo[c*DW +: DW];
        return (d == 0) ? 1 : int'(d);
    endfunction

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            m_pwm[c] = 1'b0;
            m_s[c]   = 1'b0;
            m_p[c]   = 1'b0;
            if (!rst_n) begin
                m_run[c]   = 1'b0;
                m_spend[c] = -1;
            end else if (!m_run[c]) begin
                if (en[c]) begin
                    m_run[c]   = 1'b1;
                    m_k[c]     = ph(c);
                    m_d[c]     = cur_div(c);
                    m_start[c] = e + 1;
                    m_bnd[c]   = e + 16 * m_d[c];
                    m_spend[c] = -1;
                end
            end else if (!en[c]) begin
                m_run[c]   = 1'b0;
                m_spend[c] = -1;
            end else begin
                m_pwm[c] = ((e - m_start[c]) < longint'(rom_tab[m_k[c]] * m_d[c]));
                m_s[c]   = (m_spend[c] == e);
                m_p[c]   = m_s[c] && m_pwrap[c];
                if (e == m_bnd[c]) begin
                    m_k[c]     = (m_k[c] + 1) % 8;
                    m_d[c]     = cur_div(c);
                    m_start[c] = e + 1;
                    m_bnd[c]   = e + 16 * m_d[c];
                    m_spend[c] = e + 1;
                    m_pwrap[c] = (m_k[c] == 0);
                end
            end
        end
    endtask

    // One clock: edge, model update, compare a little after the edge.
    task automatic tick();
        @(posedge clk);
        e++;
        model_step();
        #1;
        check("pwm", 64'(pwm), 64'({m_pwm[1], m_pwm[0]}));
        check("strobes", 64'({sstb, pstb}), 64'({m_s[1], m_s[0], m_p[1], m_p[0]}));
    endtask

    task automatic start_ch0(input logic [31:0] d_hi, input logic [31:0] d_lo, input logic s);
        en = '0;
        tick();
        tick();
        dhi[31:0] = d_hi;
        dlo[31:0] = d_lo;
        sel[0]    = s;
        en[0]     = 1'b1;
        tick();
    endtask

    initial begin
        int          highs;
        int          nstb;
        int          guard;
        longint      e0;
        longint      t1;
        longint      t2;
        longint      stimes [$];
        logic [31:0] set_div [3]  = '{32'd1, 32'd0, 32'd2};
        int          set_eff [3]  = '{1, 1, 2};

        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 8; k++) begin
                vecs[s*8+k].div      = set_div[s];
                vecs[s*8+k].win      = 16 * set_eff[s];
                vecs[s*8+k].exp_high = rom_tab[k] * set_eff[s];
            end
        end
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 1'b0; m_k[c] = 0; m_d[c] = 1; m_start[c] = 0;
            m_bnd[c] = 0; m_spend[c] = -1; m_pwrap[c] = 1'b0;
        end

        rst_n = 1'b0;
        en    = '0;
        sel   = '1;
        dhi   = {32'd1, 32'd1};
        dlo   = {32'd1, 32'd1};
`ifdef MODULATOR_PHASE_OFFSET_EN
        phase = '0;
`endif
        tick();
        tick();
        check("reset_outputs", 64'({pwm, sstb, pstb}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Table: per-sample high counts for divisors 1, 0 and 2 on channel 0.
        for (int i = 0; i < 24; i++) begin
            if (i == 0 || vecs[i].div != vecs[i-1].div) begin
                start_ch0(vecs[i].div, vecs[i].div, 1'b1);
            end
            highs = 0;
            for (int t = 0; t < vecs[i].win; t++) begin
                tick();
                highs += int'(pwm[0]);
            end
            check("table_highs", 64'(highs), 64'(vecs[i].exp_high));
        end

        // Period strobe position and spacing at divisor 1.
        start_ch0(32'd1, 32'd1, 1'b1);
        e0 = e; t1 = -1; t2 = -1;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (pstb[0]) begin
                if (t1 < 0) t1 = e;
                else if (t2 < 0) t2 = e;
            end
        end
        check("period_first", 64'(t1 - e0), 64'd129);
        check("period_spacing", 64'(t2 - t1), 64'd128);

        // Select flipped mid-sample, then toggled twice inside one sample.
        start_ch0(32'd1, 32'd3, 1'b1);
        e0 = e; highs = 0;
        stimes.delete();
        for (int rel = 1; rel <= 150; rel++) begin
            if (rel == 5)  sel[0] = 1'b0;
            if (rel == 30) sel[0] = 1'b1;
            if (rel == 40) sel[0] = 1'b0;
            tick();
            if (sstb[0]) stimes.push_back(e - e0);
            if (rel >= 17 && rel <= 64) highs += int'(pwm[0]);
        end
        check("sel_strobe_count", 64'(stimes.size()), 64'd3);
        if (stimes.size() >= 3) begin
            check("sel_first_len", 64'(stimes[0]), 64'd17);
            check("sel_second_len", 64'(stimes[1] - stimes[0]), 64'd48);
            check("sel_third_len", 64'(stimes[2] - stimes[1]), 64'd48);
        end
        check("sel_slow_highs", 64'(highs), 64'd39);

        // Disable exactly on a boundary, re-enable 10 cycles later.
        start_ch0(32'd1, 32'd1, 1'b1);
        guard = 0;
        while (e + 1 != m_bnd[0] && guard < 100) begin
            tick();
            guard++;
        end
        check("bnd_wait_in_budget", 64'(guard < 100), 64'd1);
        en[0] = 1'b0;
        nstb  = 0;
        highs = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            nstb  += int'(sstb[0]) + int'(pstb[0]);
            highs += int'(pwm[0]);
        end
        check("disable_no_strobe", 64'(nstb), 64'd0);
        check("disable_pwm_low", 64'(highs), 64'd0);
        en[0] = 1'b1;
        tick();
        highs = 0;
        for (int t = 0; t < 16; t++) begin
            tick();
            highs += int'(pwm[0]);
        end
        check("reenable_highs", 64'(highs), 64'd8);

        // Asynchronous reset during a high phase.
        start_ch0(32'd1, 32'd1, 1'b1);
        for (int t = 0; t < 35; t++) tick();
        check("pre_reset_high", 64'(pwm[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({pwm, sstb, pstb}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_release_low", 64'({pwm, sstb, pstb}), 64'd0);
        for (int t = 0; t < 20; t++) tick();

`ifdef MODULATOR_PHASE_OFFSET_EN
        // Multiphase start: channel 1 two samples ahead of channel 0.
        en = '0;
        tick();
        tick();
        phase = {3'd2, 3'd0};
        dhi   = {32'd1, 32'd1};
        dlo   = {32'd1, 32'd1};
        sel   = 2'b11;
        en    = 2'b11;
        tick();
        highs = 0;
        for (int t = 0; t < 16; t++) begin
            tick();
            highs += int'(pwm[1]);
        end
        check("phase_ch1_first_highs", 64'(highs), 64'd15);
        t1 = -1; t2 = -1;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (pstb[1] && t1 < 0) t1 = e;
            if (pstb[0] && t2 < 0) t2 = e;
        end
        check("phase_period_lead", 64'(t2 - t1), 64'd32);
`endif

        // Random enables, selects and divisors against the model.
        for (int t = 0; t < 4000; t++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(299) == 0) en[c] = ~en[c];
                if ($urandom_range(49) == 0)  sel[c] = ~sel[c];
                if ($urandom_range(99) == 0) begin
                    dhi[c*DW +: DW] = 32'($urandom_range(3));
                    dlo[c*DW +: DW] = 32'($urandom_range(3));
                end
`ifdef MODULATOR_PHASE_OFFSET_EN
                if ($urandom_range(19) == 0) phase[c*DEP +: DEP] = 3'($urandom_range(7));
`endif
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modulator_mc.md
# modulator_mc

Multi-channel, parametrised successor of the single-channel sine PWM modulator. Each of `CHANNELS_P` channels steps through a shared 2^`DEPTH_P`-entry sine table of `WIDTH_P`-bit amplitudes and emits one PWM period per sample. Each channel selects between two run-time frequency divisors, with glitch-free switching at sample boundaries and per-channel enable. The block sits between the board switch/control logic and the LED/PWM pins.

## Interface

Parameters:
- `CHANNELS_P`, 2: number of independent channels.
- `DEPTH_P`, 8: log2 of samples per sine period.
- `WIDTH_P`, 12: amplitude bits; also the PWM counter width.
- `DIV_W_P`, 32: width of each divisor.

Ports (one clock; reset is asynchronous and active-low):
- `clk_in`, in, 1: system clock.
- `rst_n_in`, in, 1: asynchronous active-low reset.
- `en_in`, in, `CHANNELS_P`: per-channel run enable.
- `sel_in`, in, `CHANNELS_P`: per-channel frequency select; 1 selects high, 0 selects low.
- `div_high_in`, in, `CHANNELS_P*DIV_W_P`: per-channel high-frequency divisor. Channel i occupies bits [i*DIV_W_P +: DIV_W_P].
- `div_low_in`, in, `CHANNELS_P*DIV_W_P`: per-channel low-frequency divisor, same packing.
- `phase_in`, in, `CHANNELS_P*DEPTH_P`: per-channel start sample index. Present only with `MODULATOR_PHASE_OFFSET_EN`.
- `pwm_out`, out, `CHANNELS_P`: PWM outputs.
- `sample_stb_out`, out, `CHANNELS_P`: one-cycle pulse per sample advance.
- `period_stb_out`, out, `CHANNELS_P`: one-cycle pulse when the sample index wraps to 0.

## Operation

- Sine ROM entry k = floor((2^WIDTH_P−1)·(1+sin(2πk/2^DEPTH_P))/2 + 0.5).
  - Built at elaboration.
  - Read combinationally, replicated per channel.
- Per-channel registers:
  - state (IDLE/RUN)
  - `div_act` (DIV_W_P bits)
  - prescaler `pre_cnt` (DIV_W_P bits)
  - `pwm_cnt` (WIDTH_P bits)
  - `idx` (DEPTH_P bits)
  - `sample_r` (WIDTH_P bits)
- IDLE: all counters are 0 and `pwm_out`/strobes are 0. When `en_in[i]`=1 is sampled:
  - `div_act` ← selected divisor.
  - `idx` ← phase offset.
  - `sample_r` ← rom[phase offset].
  - `pre_cnt`, `pwm_cnt` ← 0.
  - Move to RUN.
- RUN, prescaler:
  - tick = (`pre_cnt` ≥ `div_act`−1).
  - On tick `pre_cnt` ← 0, else `pre_cnt` ← `pre_cnt`+1.
  - `div_act` of 0 behaves as 1 (tick every cycle).
- RUN, PWM: on tick `pwm_cnt` ← `pwm_cnt`+1, wrapping modulo 2^WIDTH_P.
- Sample boundary = tick with `pwm_cnt` = 2^WIDTH_P−1. At the boundary:
  - `idx` ← `idx`+1 (modulo 2^DEPTH_P).
  - `sample_r` ← rom[`idx`+1].
  - `div_act` ← currently selected divisor. `sel_in` and divisor changes take effect only here.
  - `sample_stb_out` pulses.
  - `period_stb_out` pulses when the new `idx` is 0.
- `pwm_out[i]` register ← (RUN && `pwm_cnt` < `sample_r`).
  - Duty is `sample_r`/2^WIDTH_P.
  - Sample 0 gives constant low; the maximum is high for 2^WIDTH_P−1 of 2^WIDTH_P ticks.
- RUN with `en_in[i]`=0 sampled → IDLE next cycle, `pwm_out[i]`=0, strobes 0. Re-enable restarts from the phase offset.
- Output frequency = f_clk / (div·2^WIDTH_P·2^DEPTH_P).
- Channels are fully independent; no shared state except ROM contents.

## Timing

- Reset (async assert): all channels IDLE; every counter, `div_act`, `idx`, `sample_r`, `pwm_out`, `sample_stb_out` and `period_stb_out` = 0.
- `en_in` sampled high at edge n → RUN from edge n. `pwm_out` reflects `pwm_cnt`=0 vs `sample_r` after edge n+1 (one-cycle registered lag).
- Strobes assert in the cycle after the boundary edge, aligned with the first `pwm_out` value of the new sample.
- Divisor change mid-sample: no effect until the next boundary. `sel_in` toggled twice within one sample: only the value at the boundary counts.
- `en_in` fall coinciding with a boundary: disable wins; no strobe is emitted.
- Reset mid-operation: immediate return to reset values; no partial period continues after release.

## Configuration

- `MODULATOR_PHASE_OFFSET_EN` defined: `phase_in` port exists; each channel starts at its own index, enabling quadrature/multiphase outputs.
- Undefined: no `phase_in` port; all start indices are 0.

## Test plan

Bench parameters: `CHANNELS_P`=2, `DEPTH_P`=3, `WIDTH_P`=4; ROM = 8,13,15,13,8,2,0,2.

- Both divisors=1, `sel_in`=1, `en_in`=01 → ch0 highs per 16-cycle window are 8,13,15,13,8,2,0,2. `period_stb_out[0]` pulses every 128 cycles. ch1 stays 0.
- `div_high`=1, `div_low`=3; `sel_in[0]` flipped to 0 mid-sample → current sample stays 16 cycles; following samples last 48 cycles with the same duty sequence.
- `div_act`=0 → identical waveform to div=1.
- `MODULATOR_PHASE_OFFSET_EN` with `phase_in` = ch0 0, ch1 2 (enabled same cycle) → ch1 first sample 15 high cycles. ch1 period strobes lead ch0 by 32 cycles.
- Drop `en_in[0]` at a boundary, re-enable 10 cycles later → `pwm_out[0]`=0 with no strobe. Restart from index 0 gives 8 high cycles.
- Assert `rst_n_in` low mid-high-phase → `pwm_out` and strobes drop to 0 without waiting for a clock edge; after release, outputs stay 0 until `en_in` is sampled.
